// File: rtl/beamform_trigger_core.sv
// rtl/beamform_trigger_core.sv - delay-and-sum beam power trigger with staged thresholds
// Five-stage pipeline: capture/history, beam sums, squares, power, threshold compare.
module beamform_trigger_core #(
  parameter int NBEAMS = 2,
  parameter int NSAMP = 8,
  parameter logic [NBEAMS*8*4-1:0] BEAM_DELAYS = '0,
  localparam int NCHAN = 8,
  localparam int AGC_BITS = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NCHAN-1:0][AGC_BITS*NSAMP-1:0]  data_i,
  input  logic [35:0]                           thresh_i,
  input  logic [1:0]                            thresh_wr_i,
  input  logic [1:0]                            thresh_update_i,
  output logic [1:0][NBEAMS-1:0]                trigger_o
);

  localparam int WORD_W = AGC_BITS * NSAMP;
  // Enough previous words that a 15-sample delay never reaches past the window.
  localparam int NHIST = (15 + NSAMP - 1) / NSAMP;
  localparam int WIN_W = (NHIST + 1) * WORD_W;

  logic [NCHAN-1:0][WORD_W-1:0]             cur_q;
  logic [NHIST-1:0][NCHAN-1:0][WORD_W-1:0]  hist_q;
  logic [NCHAN-1:0][WIN_W-1:0]              win;
  logic [NBEAMS-1:0][NSAMP-1:0][7:0]        beam_d, beam_q;
  logic [NBEAMS-1:0][NSAMP-1:0][14:0]       sq_d, sq_q;
  logic [NBEAMS-1:0][17:0]                  pwr_d, pwr_q;
  logic [1:0][NBEAMS-1:0][17:0]             stage_q, active_q;
  logic [1:0][NBEAMS-1:0]                   trig_d;

  function automatic int beam_delay(int b, int c);
    return int'(BEAM_DELAYS[(b*8+c)*4 +: 4]);
  endfunction

  // Window per channel: oldest history word in the low slot, current word on top.
  for (genvar c = 0; c < NCHAN; c++) begin : g_win
    assign win[c][NHIST*WORD_W +: WORD_W] = cur_q[c];
    for (genvar h = 0; h < NHIST; h++) begin : g_hist
      assign win[c][(NHIST-1-h)*WORD_W +: WORD_W] = hist_q[h][c];
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    beam_d = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        for (int c = 0; c < NCHAN; c++) begin
          idx = NHIST*NSAMP + s - beam_delay(b, c);
          beam_d[b][s] = beam_d[b][s] +
            {{(8-AGC_BITS){win[c][idx*AGC_BITS + AGC_BITS-1]}}, win[c][idx*AGC_BITS +: AGC_BITS]};
        end
      end
    end
  end

  // Squaring the magnitude keeps the multiplier unsigned; |-128| fits in 8 bits.
  always_comb begin
    logic [7:0] mag;
    mag = '0;
    sq_d = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        mag = beam_q[b][s][7] ? (~beam_q[b][s] + 8'd1) : beam_q[b][s];
        sq_d[b][s] = 15'(mag) * 15'(mag);
      end
    end
  end

  always_comb begin
    pwr_d = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        pwr_d[b] = pwr_d[b] + 18'(sq_q[b][s]);
      end
    end
  end

  always_comb begin
    trig_d = '0;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < NBEAMS; b++) begin
        trig_d[k][b] = pwr_q[b] > active_q[k][b];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q     <= '0;
      hist_q    <= '0;
      beam_q    <= '0;
      sq_q      <= '0;
      pwr_q     <= '0;
      trigger_o <= '0;
    end else begin
      cur_q     <= data_i;
      hist_q[0] <= cur_q;
      for (int h = 1; h < NHIST; h++) begin
        hist_q[h] <= hist_q[h-1];
      end
      beam_q    <= beam_d;
      sq_q      <= sq_d;
      pwr_q     <= pwr_d;
      trigger_o <= trig_d;
    end
  end

  // Update samples the pre-shift staging value when a write lands in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q  <= {(2*NBEAMS){18'h3FFFF}};
      active_q <= {(2*NBEAMS){18'h3FFFF}};
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (thresh_update_i[k]) begin
          active_q[k] <= stage_q[k];
        end
        if (thresh_wr_i[k]) begin
          stage_q[k][0] <= thresh_i[18*k +: 18];
          for (int b = 1; b < NBEAMS; b++) begin
            stage_q[k][b] <= stage_q[k][b-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_beamform_trigger_core.sv
// tb/tb_beamform_trigger_core.sv - beamform trigger bench against a sample-stream power model
`timescale 1ns/1ps
module tb_beamform_trigger_core;
  localparam int NB = 2;
  localparam int NS = 8;
  localparam int NC = 8;
  // Beam 0 all zero delay; beam 1 per-channel delays c0..c7 = 0,1,3,9,0,7,8,15.
  localparam logic [63:0] DLY = 64'hF870_9310_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0][5*NS-1:0] data_in;
  logic [35:0] thr;
  logic [1:0] wr, upd;
  logic [1:0][NB-1:0] trig;
  logic chk_en = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beamform_trigger_core #(.NBEAMS(NB), .NSAMP(NS), .BEAM_DELAYS(DLY)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .data_i(data_in),
    .thresh_i(thr),
    .thresh_wr_i(wr),
    .thresh_update_i(upd),
    .trigger_o(trig)
  );

  logic [NC-1:0][5*NS-1:0] wq[$];
  logic [17:0] m_stage[2][NB];
  logic [17:0] m_act[2][NB];
  logic [1:0][NB-1:0] exp_trig;

  function automatic int delay_of(int b, int c);
    logic [63:0] d;
    d = DLY;
    return int'(d[(b*8+c)*4 +: 4]);
  endfunction

  function automatic int sample_at(int c, int m);
    logic [NC-1:0][5*NS-1:0] w;
    logic signed [4:0] v;
    if (m < 0) return 0;
    w = wq[m / NS];
    v = w[c][(m % NS)*5 +: 5];
    return int'(v);
  endfunction

  function automatic int beam_power(int w, int b);
    int p, y;
    p = 0;
    for (int s = 0; s < NS; s++) begin
      y = 0;
      for (int c = 0; c < NC; c++) y += sample_at(c, NS*w + s - delay_of(b, c));
      p += y * y;
    end
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int e, p;
    if (!rst_n) begin
      wq.delete();
      exp_trig = '0;
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < NB; b++) begin
          m_stage[k][b] = 18'h3FFFF;
          m_act[k][b] = 18'h3FFFF;
        end
    end else begin
      wq.push_back(data_in);
      e = wq.size() - 1;
      for (int b = 0; b < NB; b++) begin
        p = (e >= 4) ? beam_power(e - 4, b) : 0;
        for (int k = 0; k < 2; k++) exp_trig[k][b] = (p > int'(m_act[k][b]));
      end
      for (int k = 0; k < 2; k++) begin
        if (upd[k]) for (int b = 0; b < NB; b++) m_act[k][b] = m_stage[k][b];
        if (wr[k]) begin
          for (int b = NB-1; b > 0; b--) m_stage[k][b] = m_stage[k][b-1];
          m_stage[k][0] = thr[18*k +: 18];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (trig !== exp_trig) begin
        errors++;
        $display("FAIL model_cmp t=%0t trigger_o=%b expected=%b", $time, trig, exp_trig);
      end
    end
  end

  task automatic check_lit(string name, logic [3:0] expv);
    checks++;
    if (trig !== expv) begin
      errors++;
      $display("FAIL %s: trigger_o=%b expected=%b", name, trig, expv);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_all(logic [4:0] v);
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++) data_in[c][s*5 +: 5] = v;
  endtask

  // First value lands in beam 1, second in beam 0, then update.
  task automatic load(logic [1:0] mask, logic [17:0] first, logic [17:0] second);
    step(); thr = {first, first}; wr = mask;
    step(); thr = {second, second};
    step(); wr = 2'b00; upd = mask;
    step(); upd = 2'b00;
  endtask

  initial begin
    data_in = '0; thr = '0; wr = '0; upd = '0;
    step(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check_lit("reset", 4'b0000);

    set_all(5'd1);
    step(8);
    check_lit("no_update", 4'b0000);

    load(2'b11, 18'd511, 18'd511);
    step(8);
    check_lit("thr511", 4'b1111);
    load(2'b11, 18'd512, 18'd512);
    step(8);
    check_lit("thr512", 4'b0000);

    set_all(5'b10000);
    step(8);
    check_lit("neg16_thr512", 4'b1111);
    load(2'b11, 18'h1FFFF, 18'h1FFFF);
    step(8);
    check_lit("max_thr1ffff", 4'b1111);
    load(2'b11, 18'h20000, 18'h20000);
    step(8);
    check_lit("max_thr20000", 4'b0000);

    data_in = '0;
    data_in[0][4:0] = 5'd11;
    data_in[0][9:5] = 5'd5;
    data_in[0][14:10] = 5'd2;
    load(2'b01, 18'd100, 18'd200);
    step(8);
    check_lit("chain_order", 4'b0010);

    load(2'b01, 18'd0, 18'd0);
    load(2'b10, 18'd400, 18'd400);
    data_in = '0;
    step(8);
    check_lit("quiet", 4'b0000);
    step();
    data_in[0][19:15] = 5'd15;
    data_in[1][19:15] = 5'b10001;
    step();
    data_in = '0;
    step(3);
    check_lit("pulse_pre", 4'b0000);
    step();
    check_lit("pulse_hit", 4'b1010);
    step();
    check_lit("pulse_post", 4'b0000);
    step(4);
    data_in[0][39:35] = 5'd15;
    data_in[1][39:35] = 5'b10001;
    step();
    data_in = '0;
    step(4);
    check_lit("split_a", 4'b0010);
    step();
    check_lit("split_b", 4'b0010);
    step();
    check_lit("split_end", 4'b0000);

    set_all(5'd1);
    step(); thr = {18'd0, 18'd600}; wr = 2'b01;
    step();
    step(); thr = {18'd0, 18'd100}; upd = 2'b01;
    step(); wr = 2'b00; upd = 2'b00;
    step(8);
    check_lit("wr_upd_same", 4'b1100);
    step(); upd = 2'b01;
    step(); upd = 2'b00;
    step(8);
    check_lit("upd_after_shift", 4'b1101);

    step();
    #2 rst_n = 1'b0;
    #1 check_lit("async_reset", 4'b0000);
    step();
    #2 rst_n = 1'b1;
    step(10);
    check_lit("post_reset", 4'b0000);

    for (int i = 0; i < 3000; i++) begin
      step();
      case ($urandom_range(0, 3))
        0: for (int c = 0; c < NC; c++)
             for (int s = 0; s < NS; s++) data_in[c][s*5 +: 5] = 5'($urandom);
        1: for (int c = 0; c < NC; c++)
             for (int s = 0; s < NS; s++) data_in[c][s*5 +: 5] = 5'($urandom_range(0, 6)) - 5'd3;
        2: ;
        default: data_in = '0;
      endcase
      thr = {18'($urandom_range(0, 12000)), 18'($urandom_range(0, 12000))};
      wr  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      upd = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
      end
    end
    wr = '0; upd = '0;
    step(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
